lsu_ctrl: RTL

- Load/store sequencing controller between the pipeline MEM stage and a word-addressed data memory with a req/ack handshake.
- Accepts one load or store per transaction and decodes the access from the instruction word (opcode inst[6:0], funct3 inst[14:12]).
- Splits accesses that cross a word boundary into two memory beats, then merges, aligns and sign/zero-extends load data.
- Returns a single-cycle response and flags illegal encodings and memory timeouts.

---
 rtl/lsu_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the MEM stage and a word-addressed
// data memory with a req/ack handshake.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   req_valid/req_ready   access handshake from the pipeline
//   inst, addr, wdata     instruction word, byte address, right-aligned store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata, resp_err  extended load data and error flag, valid with resp_valid
//   mem_req, mem_we       memory beat request / write beat
//   mem_addr, mem_be      word-aligned beat address and byte-lane enables
//   mem_wdata             lane-aligned write data
//   mem_ack, mem_rdata    beat completion and read data from memory
//
// Accesses crossing a word boundary are split into two beats (word, word+4).
// Every memory and response output is decoded from registered state only.
module lsu_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] inst,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [31:0] TO       = 32'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    // Latched access; only the fields the datapath needs are kept.
    typedef struct packed {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;

    // Instruction bits outside opcode/funct3 carry no meaning here.
    logic unused_inst;
    assign unused_inst = ^{inst[WIDTH-1:15], inst[11:7]};

    // ---------------- decode of the incoming instruction ----------------
    logic [2:0] f3_in;
    logic       is_ld, is_st, legal;

    always_comb begin
        f3_in = inst[14:12];
        is_ld = (inst[6:0] == OP_LOAD);
        is_st = (inst[6:0] == OP_STORE);
        legal = 1'b0;
        if (is_ld) begin
            case (f3_in)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                default:                                legal = 1'b0;
            endcase
        end else if (is_st) begin
            case (f3_in)
                3'b000, 3'b001, 3'b010: legal = 1'b1;
                default:                legal = 1'b0;
            endcase
        end
    end

    // ---------------- size / split / lane alignment ----------------
    logic [1:0]  off;
    logic [2:0]  size;
    logic [7:0]  mask;
    logic        split;
    logic [7:0]  be8;
    logic [63:0] wd64;
    logic [63:0] r64;
    logic [31:0] r;
    logic [31:0] word_addr;
    logic [31:0] ld_data;

    always_comb begin
        off = req_q.addr[1:0];
        case (req_q.f3[1:0])
            2'b00:   begin size = 3'd1; mask = 8'h01; end
            2'b01:   begin size = 3'd2; mask = 8'h03; end
            default: begin size = 3'd4; mask = 8'h0F; end
        endcase
        split     = ({1'b0, off} + size) > 3'd4;
        be8       = mask << off;
        wd64      = {32'b0, req_q.wdata} << {off, 3'b000};
        // hi_q is held at zero for non-split loads, so the shift is uniform.
        r64       = {hi_q, lo_q} >> {off, 3'b000};
        r         = r64[31:0];
        word_addr = {req_q.addr[31:2], 2'b00};
        case (req_q.f3)
            3'b000:  ld_data = {{24{r[7]}}, r[7:0]};
            3'b100:  ld_data = {24'b0, r[7:0]};
            3'b001:  ld_data = {{16{r[15]}}, r[15:0]};
            3'b101:  ld_data = {16'b0, r[15:0]};
            default: ld_data = r;
        endcase
    end

    // ---------------- timeout ----------------
    // Expires on the cycle the count would reach TIMEOUT without an ack;
    // an ack in that same cycle still wins because ack is tested first.
    logic expire;
    assign expire = (TIMEOUT != 0) && ((cnt_q + 32'd1) == TO);

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    req_d.st    = is_st;
                    req_d.f3    = f3_in;
                    req_d.addr  = addr;
                    req_d.wdata = wdata;
                    lo_d        = '0;
                    hi_d        = '0;
                    cnt_d       = '0;
                    err_d       = !legal;
                    state_d     = legal ? ACC0 : RESP;
                end
            end
            ACC0: begin
                if (mem_ack) begin
                    lo_d    = mem_rdata;
                    cnt_d   = '0;
                    state_d = split ? ACC1 : RESP;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ACC1: begin
                if (mem_ack) begin
                    hi_d    = mem_rdata;
                    state_d = RESP;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- outputs (Moore) ----------------
    always_comb begin
        req_ready  = (state_q == IDLE) && !rst;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        case (state_q)
            ACC0: begin
                mem_req   = 1'b1;
                mem_we    = req_q.st;
                mem_addr  = word_addr;
                mem_be    = be8[3:0];
                mem_wdata = wd64[31:0];
            end
            ACC1: begin
                mem_req   = 1'b1;
                mem_we    = req_q.st;
                mem_addr  = word_addr + 32'd4;
                mem_be    = be8[7:4];
                mem_wdata = wd64[63:32];
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q || req_q.st) ? 32'b0 : ld_data;
            end
            default: ;
        endcase
    end

endmodule
